// File: rtl/spart_pkg.sv
// Shared types and helpers for the SPART bus driver: bus address map, baud selections
// and the divisor arithmetic used to program the SPART baud generator.
package spart_pkg;

  typedef enum logic [1:0] {
    IOA_BUF    = 2'b00,
    IOA_STATUS = 2'b01,
    IOA_DB_LO  = 2'b10,
    IOA_DB_HI  = 2'b11
  } ioaddr_t;

  typedef enum logic [1:0] {
    BAUD_4800  = 2'b00,
    BAUD_9600  = 2'b01,
    BAUD_19200 = 2'b10,
    BAUD_38400 = 2'b11
  } baud_t;

  localparam int unsigned BAUD_TABLE [4] = '{4800, 9600, 19200, 38400};

  function automatic logic [15:0] divisor(input int unsigned clk_hz, input int unsigned baud);
    int unsigned quot;
    quot = clk_hz / baud;
    return quot[15:0];
  endfunction

  // Letters get bit 5 inverted (upper <-> lower case); everything else is untouched.
  function automatic logic [7:0] case_flip(input logic [7:0] b);
    logic is_alpha;
    is_alpha = ((b >= 8'h41) && (b <= 8'h5A)) || ((b >= 8'h61) && (b <= 8'h7A));
    return is_alpha ? (b ^ 8'h20) : b;
  endfunction

endpackage

// File: rtl/spart_driver_echo_fifo.sv
// Small elastic FIFO holding received bytes until the SPART can take them back.
// Pointers wrap naturally; a separate count keeps full and empty unambiguous.
module echo_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/spart_driver.sv
// Processor-side SPART bus master: programs the baud divisor, then echoes received bytes.
// Define DRIVER_CASE_FLIP_EN to swap the case of ASCII letters as they are echoed.
module spart_driver
  import spart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    br_cfg,
  input  logic                          rda,
  input  logic                          tbr,
  output logic                          iocs,
  output logic                          iorw,
  output logic [1:0]                    ioaddr,
  inout  wire  [7:0]                    databus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          cfg_busy
);

  typedef enum logic [2:0] {
    CFG_LO, CFG_HI, IDLE, RD, RD_HOLD, WR, WR_HOLD
  } drv_state_t;

  localparam logic [15:0] DIV_TABLE [4] = '{
    divisor(CLK_FREQ_HZ, BAUD_TABLE[0]),
    divisor(CLK_FREQ_HZ, BAUD_TABLE[1]),
    divisor(CLK_FREQ_HZ, BAUD_TABLE[2]),
    divisor(CLK_FREQ_HZ, BAUD_TABLE[3])
  };

  drv_state_t state_q, state_d;
  logic       armed_q, armed_d;
  baud_t      br_cur_q, br_cur_d;
  baud_t      br_tgt_q, br_tgt_d;
  logic       iocs_q, iocs_d;
  logic       iorw_q, iorw_d;
  ioaddr_t    ioaddr_q, ioaddr_d;
  logic [7:0] dout_q, dout_d;
  logic       cfg_busy_q, cfg_busy_d;

  logic [1:0] br_meta_q;
  baud_t      br_sync_q;

  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_din, fifo_dout;

  // Switches are asynchronous; the synchronizer is left unreset so it is already settled
  // when reset releases and the very first divisor write uses the real switch setting.
  always_ff @(posedge clk) begin
    br_meta_q <= br_cfg;
    br_sync_q <= baud_t'(br_meta_q);
  end

`ifdef DRIVER_CASE_FLIP_EN
  assign fifo_din = case_flip(databus);
`else
  assign fifo_din = databus;
`endif

  echo_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Bus outputs are decoded from the next state so each registered access lines up with
  // its state. Out of reset the FSM sits in CFG_LO with the bus idle; armed_q lets that
  // first CFG_LO access reach the bus one cycle later instead of being skipped.
  always_comb begin
    state_d   = state_q;
    armed_d   = 1'b1;
    br_cur_d  = br_cur_q;
    br_tgt_d  = br_tgt_q;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;

    if (!armed_q) begin
      state_d = CFG_LO;
    end else begin
      case (state_q)
        CFG_LO:  state_d = CFG_HI;
        CFG_HI: begin
          state_d  = IDLE;
          br_cur_d = br_tgt_q;
        end
        IDLE: begin
          if (br_sync_q != br_cur_q)    state_d = CFG_LO;
          else if (rda && !fifo_full)   state_d = RD;
          else if (tbr && !fifo_empty)  state_d = WR;
          else                          state_d = IDLE;
        end
        RD: begin
          fifo_push = 1'b1;
          state_d   = RD_HOLD;
        end
        RD_HOLD: state_d = IDLE;
        WR: begin
          fifo_pop = 1'b1;
          state_d  = WR_HOLD;
        end
        WR_HOLD: state_d = IDLE;
        default: state_d = CFG_LO;
      endcase
    end

    iocs_d     = 1'b0;
    iorw_d     = 1'b1;
    ioaddr_d   = IOA_BUF;
    dout_d     = 8'h00;
    cfg_busy_d = 1'b0;
    case (state_d)
      CFG_LO: begin
        iocs_d     = 1'b1;
        iorw_d     = 1'b0;
        ioaddr_d   = IOA_DB_LO;
        dout_d     = DIV_TABLE[br_sync_q][7:0];
        cfg_busy_d = 1'b1;
        br_tgt_d   = br_sync_q;
      end
      CFG_HI: begin
        iocs_d     = 1'b1;
        iorw_d     = 1'b0;
        ioaddr_d   = IOA_DB_HI;
        dout_d     = DIV_TABLE[br_tgt_q][15:8];
        cfg_busy_d = 1'b1;
      end
      RD: begin
        iocs_d = 1'b1;
        iorw_d = 1'b1;
      end
      WR: begin
        iocs_d = 1'b1;
        iorw_d = 1'b0;
        dout_d = fifo_dout;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CFG_LO;
      armed_q    <= 1'b0;
      br_cur_q   <= BAUD_4800;
      br_tgt_q   <= BAUD_4800;
      iocs_q     <= 1'b0;
      iorw_q     <= 1'b1;
      ioaddr_q   <= IOA_BUF;
      dout_q     <= 8'h00;
      cfg_busy_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      br_cur_q   <= br_cur_d;
      br_tgt_q   <= br_tgt_d;
      iocs_q     <= iocs_d;
      iorw_q     <= iorw_d;
      ioaddr_q   <= ioaddr_d;
      dout_q     <= dout_d;
      cfg_busy_q <= cfg_busy_d;
    end
  end

  assign iocs     = iocs_q;
  assign iorw     = iorw_q;
  assign ioaddr   = ioaddr_q;
  assign cfg_busy = cfg_busy_q;
  assign databus  = (iocs_q && !iorw_q) ? dout_q : 8'hzz;

endmodule
